// File: rtl/font_pkg.sv
// Shared font geometry, pixel/letter types and line-controller state encoding.
package font_pkg;
  localparam int GLYPH_W     = 16;
  localparam int GLYPH_H     = 16;
  localparam int SCALE_SHIFT = 1;
  // log2(GLYPH_W) + SCALE_SHIFT: pixel-offset bit where the slot index starts
  localparam int SLOT_SHIFT  = 5;

  typedef logic [4:0]  letter_t;
  typedef logic [11:0] rgb_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } line_state_t;
endpackage

// File: rtl/glyph_rom.sv
// Glyph store: 32 glyphs x 16 rows x 16 bits, bit 15 is the leftmost column, glyph 0 blank.
// Latency: 1 cycle (registered row). No backpressure; a new lookup is accepted every cycle.
// Bitmaps are a boxed pattern font: full top/bottom rows, side rails, code-dependent interior.
module glyph_rom
  import font_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [4:0]  letter_in,
  input  logic [3:0]  row_in,
  output logic [15:0] row_out
);

  function automatic logic [15:0] glyph_bits(input letter_t l, input logic [3:0] r);
    logic [15:0] bits;
    if (l == 5'd0) begin
      bits = 16'h0000;
    end else if (r == 4'd0 || r == 4'd15) begin
      bits = 16'hFFFF;
    end else begin
      bits = ({l, ~l, l, 1'b0} ^ {12'h000, r}) | 16'h8001;
    end
    return bits;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      row_out <= '0;
    end else begin
      row_out <= glyph_bits(letter_in, row_in);
    end
  end

endmodule

// File: rtl/text_line_ctrl.sv
// Text line overlay: NUM_CHARS 16x16 glyph slots drawn at 2x scale from (X_POS, Y_POS).
// Latency: 2 cycles hcount/vcount -> pixel_out/in_sprite_out; writes held off (wr_ready_out=0) while clearing.
// Define TEXT_BLINK_EN to add a 6-bit frame counter that hides the line while blink_in is set.
module text_line_ctrl
  import font_pkg::*;
#(
  parameter int X_POS     = 128,
  parameter int Y_POS     = 128,
  parameter int NUM_CHARS = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        wr_valid_in,
  output logic        wr_ready_out,
  input  logic [3:0]  wr_addr_in,
  input  logic [4:0]  wr_letter_in,
  input  logic        clear_in,
  input  logic [11:0] color_in,
  input  logic        blink_in,
  output logic [11:0] pixel_out,
  output logic        in_sprite_out
);

  localparam int X_END = X_POS + (NUM_CHARS << SLOT_SHIFT);
  localparam int Y_END = Y_POS + (GLYPH_H << SCALE_SHIFT);

  line_state_t state, state_nxt;
  logic [3:0]  clr_idx, clr_idx_nxt;
  logic        clr_en;
  logic        wr_en;
  letter_t     letters [16];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_idx_nxt  = clr_idx;
    clr_en       = 1'b0;
    wr_ready_out = 1'b0;
    case (state)
      IDLE: begin
        wr_ready_out = !clear_in;
        clr_idx_nxt  = 4'd0;
        if (clear_in) state_nxt = CLEAR;
      end
      CLEAR: begin
        clr_en      = 1'b1;
        clr_idx_nxt = clr_idx + 4'd1;
        if (clr_idx == 4'(NUM_CHARS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range addresses complete the handshake but never touch storage.
  assign wr_en = wr_valid_in && wr_ready_out && ({1'b0, wr_addr_in} < 5'(NUM_CHARS));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 16; i++) letters[i] <= '0;
    end else if (clr_en) begin
      letters[clr_idx] <= '0;
    end else if (wr_en) begin
      letters[wr_addr_in] <= wr_letter_in;
    end
  end

  // Region test is done on raw coordinates so nothing left/above the line can wrap in.
  logic        in_region;
  logic [10:0] dx;
  logic [9:0]  dy;
  logic        unused_coord;

  assign in_region = (hcount_in >= 11'(X_POS)) && ({1'b0, hcount_in} < 12'(X_END)) &&
                     (vcount_in >= 10'(Y_POS)) && ({1'b0, vcount_in} < 11'(Y_END));
  assign dx = hcount_in - 11'(X_POS);
  assign dy = vcount_in - 10'(Y_POS);
  assign unused_coord = ^{dx, dy};

  logic        s1_vld;
  letter_t     s1_letter;
  logic [3:0]  s1_col, s1_row;
  logic        s2_vld;
  logic [3:0]  s2_col;
  rgb_t        s2_color;
  logic [15:0] glyph_row;
  logic        s2_lit;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_vld    <= 1'b0;
      s1_letter <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s2_vld    <= 1'b0;
      s2_col    <= '0;
      s2_color  <= '0;
    end else begin
      s1_vld    <= in_region;
      s1_letter <= in_region ? letters[dx[SLOT_SHIFT+3:SLOT_SHIFT]] : '0;
      s1_col    <= dx[SCALE_SHIFT+3:SCALE_SHIFT];
      s1_row    <= dy[SCALE_SHIFT+3:SCALE_SHIFT];
      s2_vld    <= s1_vld && (s1_letter != '0);
      s2_col    <= s1_col;
      s2_color  <= color_in;
    end
  end

  glyph_rom u_glyph_rom (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .letter_in (s1_letter),
    .row_in    (s1_row),
    .row_out   (glyph_row)
  );

  assign s2_lit = s2_vld && glyph_row[4'd15 - s2_col];

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt <= '0;
    end else if (hcount_in == '0 && vcount_in == '0) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign in_sprite_out = s2_lit && !(blink_in && frame_cnt[5]);
`else
  logic unused_blink;
  assign unused_blink  = blink_in;
  assign in_sprite_out = s2_lit;
`endif

  assign pixel_out = in_sprite_out ? s2_color : 12'h000;

endmodule

// File: tb/tb_text_line_ctrl.sv
// Bench for text_line_ctrl: fixed vectors, hand sequences for clear/reset/range corners, random traffic vs a model.
`timescale 1ns/1ps
module tb_text_line_ctrl;
  localparam int XP  = 128, YP  = 128, NC  = 16;
  localparam int XP8 = 64,  YP8 = 300, NC8 = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        wr_valid_in;
  logic        wr_ready_out;
  logic [3:0]  wr_addr_in;
  logic [4:0]  wr_letter_in;
  logic        clear_in;
  logic [11:0] color_in;
  logic        blink_in;
  logic [11:0] pixel_out;
  logic        in_sprite_out;
  logic        w8_valid, w8_ready, sprite8;
  logic [11:0] pixel8;

  always #5 clk_in = ~clk_in;

  text_line_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out), .wr_addr_in(wr_addr_in),
    .wr_letter_in(wr_letter_in), .clear_in(clear_in), .color_in(color_in), .blink_in(blink_in),
    .pixel_out(pixel_out), .in_sprite_out(in_sprite_out)
  );

  text_line_ctrl #(.X_POS(XP8), .Y_POS(YP8), .NUM_CHARS(NC8)) dut8 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .wr_valid_in(w8_valid), .wr_ready_out(w8_ready), .wr_addr_in(wr_addr_in),
    .wr_letter_in(wr_letter_in), .clear_in(clear_in), .color_in(color_in), .blink_in(blink_in),
    .pixel_out(pixel8), .in_sprite_out(sprite8)
  );

  int n_chk = 0, n_err = 0;
  int mbuf [NC];
  int busy_left;
  bit p1_lit, exp_lit;
  int exp_color;
  int m_frame;

  typedef struct { int h; int v; bit lit; } vec_t;
  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference font: full rows 0 and 15, else interior pattern from the code with side rails.
  function automatic int font_bit(int l, int r, int c);
    int row;
    if (r == 0 || r == 15) row = 'hFFFF;
    else row = (((l << 11) | ((31 - l) << 6) | (l << 1)) ^ r) | 'h8001;
    return (row >> (15 - c)) & 1;
  endfunction

  function automatic bit model_lit(int h, int v);
    int dx, dy, l;
    dx = h - XP;
    dy = v - YP;
    if (dx < 0 || dx >= 32 * NC || dy < 0 || dy >= 32) return 1'b0;
    l = mbuf[dx / 32];
    if (l == 0) return 1'b0;
    return font_bit(l, dy / 2, (dx / 2) % 16) == 1;
  endfunction

  function automatic bit blanked();
`ifdef TEXT_BLINK_EN
    return blink_in && ((m_frame % 64) >= 32);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mbuf[i] = 0;
    busy_left = 0; p1_lit = 0; exp_lit = 0; exp_color = 0; m_frame = 0;
  endtask

  // Check current outputs against the model, then advance one clock and the model with it.
  task automatic tick();
    bit lit_now, rdy, accept, vis;
    #1;
    rdy = (busy_left == 0) && !clear_in;
    vis = exp_lit && !blanked();
    chk("wr_ready", wr_ready_out, rdy);
    chk("in_sprite", in_sprite_out, vis);
    chk("pixel", pixel_out, vis ? exp_color : 0);
    lit_now = model_lit(hcount_in, vcount_in);
    accept  = wr_valid_in && rdy;
    @(posedge clk_in);
    exp_lit   = p1_lit;
    p1_lit    = lit_now;
    exp_color = color_in;
    if (busy_left > 0) begin
      mbuf[NC - busy_left] = 0;
      busy_left--;
    end else if (clear_in) begin
      busy_left = NC;
    end else if (accept && wr_addr_in < NC) begin
      mbuf[wr_addr_in] = wr_letter_in;
    end
    if (hcount_in == 0 && vcount_in == 0) m_frame++;
    #1;
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    #1;
    chk("rst_sprite", in_sprite_out, 0);
    chk("rst_pixel", pixel_out, 0);
    chk("rst_ready", wr_ready_out, 1);
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic write(input int addr, input int letter);
    wr_valid_in = 1'b1; wr_addr_in = 4'(addr); wr_letter_in = 5'(letter);
    tick();
    wr_valid_in = 1'b0;
  endtask

  task automatic show(input int h, input int v);
    hcount_in = 11'(h); vcount_in = 10'(v);
    tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{XP,       YP,      1'b1}, '{XP - 1,   YP,      1'b0}, '{XP + 512, YP,      1'b0},
      '{XP + 511, YP,      1'b1}, '{XP,       YP - 1,  1'b0}, '{XP,       YP + 32, 1'b0},
      '{XP,       YP + 31, 1'b1}, '{XP + 160, YP,      1'b0}, '{XP + 2,   YP + 2,  1'b0},
      '{XP + 4,   YP + 2,  1'b1}, '{XP + 5,   YP + 3,  1'b1}, '{XP + 14,  YP + 2,  1'b0},
      '{XP + 16,  YP + 2,  1'b0}, '{XP + 30,  YP + 2,  1'b1}, '{XP + 1,   YP + 1,  1'b1}
    };
    rst_n_in = 1'b0; hcount_in = '0; vcount_in = '0; wr_valid_in = 1'b0; wr_addr_in = '0;
    wr_letter_in = '0; clear_in = 1'b0; color_in = '0; blink_in = 1'b0; w8_valid = 1'b0;
    model_reset();

    #1;
    chk("reset_sprite", in_sprite_out, 0);
    chk("reset_pixel", pixel_out, 0);
    chk("reset_ready", wr_ready_out, 1);
    chk("reset_ready8", w8_ready, 1);
    @(posedge clk_in); @(posedge clk_in); #2;
    rst_n_in = 1'b1;

    // Fixed content: slot 0 = 'G' (7), slot 15 = 3, slot 5 blank.
    hcount_in = 11'(XP - 1); vcount_in = 10'(YP);
    write(0, 7); write(15, 3); write(5, 0);
    color_in = 12'hA5C;
    for (int i = 0; i < 15; i++) begin
      show(vecs[i].h, vecs[i].v);
      chk($sformatf("vec%0d_sprite", i), in_sprite_out, vecs[i].lit);
      chk($sformatf("vec%0d_pixel", i), pixel_out, vecs[i].lit ? 12'hA5C : 0);
    end

    // Exact two-cycle latency on the first lit pixel.
    show(XP - 1, YP);
    hcount_in = 11'(XP); tick();
    chk("lat1", in_sprite_out, 0);
    hcount_in = 11'(XP - 1); tick();
    chk("lat2", in_sprite_out, 1);
    chk("lat2_pixel", pixel_out, 12'hA5C);
    tick();
    chk("lat3", in_sprite_out, 0);

    // Clear collides with a write: write dropped, 16 busy cycles, everything blank.
    write(1, 9);
    clear_in = 1'b1; wr_valid_in = 1'b1; wr_addr_in = 4'd2; wr_letter_in = 5'd9;
    #1;
    chk("clr_collide_ready", wr_ready_out, 0);
    tick();
    clear_in = 1'b0; wr_valid_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("clr_busy%0d", i), wr_ready_out, 0);
      tick();
    end
    chk("clr_done_ready", wr_ready_out, 1);
    for (int s = 0; s < NC; s++) begin
      show(XP + 32 * s, YP);
      chk($sformatf("clr_slot%0d", s), in_sprite_out, 0);
    end

    // Reset in the fifth cycle of a clear.
    write(15, 3);
    show(XP + 480, YP);
    chk("pre_rst_lit", in_sprite_out, 1);
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_clear_lit", in_sprite_out, 1);
    apply_reset();
    #1;
    chk("post_rst_ready", wr_ready_out, 1);
    tick(); tick();
    chk("post_rst_blank", in_sprite_out, 0);

    // Eight-slot instance: address 15 handshakes and is discarded.
    w8_valid = 1'b1; wr_addr_in = 4'd15; wr_letter_in = 5'd7;
    #1;
    chk("w8_handshake", w8_ready, 1);
    tick();
    w8_valid = 1'b0;
    for (int s = 0; s < NC8; s++) begin
      show(XP8 + 32 * s, YP8);
      chk($sformatf("w8_slot%0d", s), sprite8, 0);
    end
    w8_valid = 1'b1; wr_addr_in = 4'd7; tick(); w8_valid = 1'b0;
    color_in = 12'h3F1;
    show(XP8 + 224, YP8);
    chk("w8_slot7_lit", sprite8, 1);
    chk("w8_slot7_pixel", pixel8, 12'h3F1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      hcount_in    = 11'($urandom_range(XP + 560, XP - 40));
      vcount_in    = 10'($urandom_range(YP + 40, YP - 8));
      if ($urandom_range(63, 0) == 0) begin
        hcount_in = '0; vcount_in = '0;
      end
      wr_valid_in  = 1'($urandom_range(1, 0));
      wr_addr_in   = 4'($urandom_range(15, 0));
      wr_letter_in = 5'($urandom_range(31, 0));
      clear_in     = ($urandom_range(59, 0) == 0);
      color_in     = 12'($urandom_range(4095, 0));
      blink_in     = 1'($urandom_range(1, 0));
      tick();
    end
    wr_valid_in = 1'b0; clear_in = 1'b0; blink_in = 1'b0;
    tick();

`ifdef TEXT_BLINK_EN
    apply_reset();
    write(0, 7);
    blink_in = 1'b1; color_in = 12'hFFF;
    for (int f = 0; f < 64; f++) begin
      show(XP, YP);
      chk($sformatf("blink_f%0d", f), in_sprite_out, (f < 32) ? 1 : 0);
      hcount_in = '0; vcount_in = '0;
      tick();
    end
    blink_in = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
